// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
// Optional feature macro: IMEM_CHECKSUM_EN (enables the CHECK state).
package imem_loader_pkg;

  localparam int IMEM_DEPTH = 16;
  localparam int IMEM_AW    = 4;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    CHECK = 2'd1,
    RUN   = 2'd2,
    ERROR = 2'd3
  } loader_state_t;

endpackage

// File: rtl/imem_array.sv
// 16x8 instruction register file: synchronous write, asynchronous read,
// synchronous clear while reset is low.
module imem_array
  import imem_loader_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               i_we,
  input  logic [IMEM_AW-1:0] i_waddr,
  input  logic [7:0]         i_wdata,
  input  logic [IMEM_AW-1:0] i_raddr,
  output logic [7:0]         o_rdata
);

  logic [7:0] r_mem [IMEM_DEPTH];

  // Clear every word on reset, otherwise write one word when enabled.
  // NOTE: the whole array is reset, so this maps to flops rather than a RAM
  //       macro; that is intended for a 16-word store that must boot clean.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < IMEM_DEPTH; i++) r_mem[i] <= 8'h00;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Fetch is combinational; a same-cycle write is visible only after the edge.
  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/imem_loader.sv
// Boot loader in front of the CPU: fills the instruction store over a
// valid/ready byte port and holds the CPU in reset until the program is in.
// Optional feature macro: IMEM_CHECKSUM_EN (17th byte is a two's-complement
// checksum; a mismatch parks the block in ERROR).
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH = IMEM_DEPTH
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] addr,
  output logic [7:0] data,
  input  logic       load_req,
  input  logic       ld_valid,
  input  logic [7:0] ld_data,
  output logic       ld_ready,
  output logic       cpu_reset_n,
  output logic       busy,
  output logic       error
);

  localparam logic [IMEM_AW-1:0] LAST_IDX = IMEM_AW'(DEPTH - 1);

  loader_state_t      r_state;
  loader_state_t      w_next_state;
  logic [IMEM_AW-1:0] r_idx;
  logic               w_xfer;
  logic               w_we;

  assign w_xfer = ld_valid && ld_ready;
  // A load_req in the same cycle drops the byte so the restart begins clean.
  assign w_we   = w_xfer && (r_state == LOAD) && !load_req;

`ifdef IMEM_CHECKSUM_EN
  logic [7:0] r_sum;
  logic [7:0] w_sum_next;

  assign w_sum_next = r_sum + ld_data;

  // Running mod-256 sum of the program bytes, restarted with every load.
  always_ff @(posedge clock) begin
    if (!reset || load_req) r_sum <= 8'h00;
    else if (w_we)          r_sum <= w_sum_next;
  end
`endif

  // State register.
  // NOTE: clocked state uses non-blocking assignment so every flop samples
  //       the pre-edge values regardless of block ordering.
  always_ff @(posedge clock) begin
    if (!reset) r_state <= LOAD;
    else        r_state <= w_next_state;
  end

  // Word index: advances on each stored byte and wraps after the last word.
  always_ff @(posedge clock) begin
    if (!reset || load_req) r_idx <= '0;
    else if (w_we)          r_idx <= r_idx + 1'b1;
  end

  // Next-state logic and state-decoded outputs.
  // NOTE: every output gets a default first so no path leaves it unassigned,
  //       which would otherwise infer a latch.
  always_comb begin
    w_next_state = r_state;
    ld_ready     = 1'b0;
    cpu_reset_n  = 1'b0;
    busy         = 1'b1;
    error        = 1'b0;

    if (load_req) begin
      w_next_state = LOAD;
    end else begin
      case (r_state)
        LOAD: begin
          if (w_xfer && (r_idx == LAST_IDX)) begin
`ifdef IMEM_CHECKSUM_EN
            w_next_state = CHECK;
`else
            w_next_state = RUN;
`endif
          end
        end
`ifdef IMEM_CHECKSUM_EN
        CHECK: begin
          if (w_xfer) w_next_state = (w_sum_next == 8'h00) ? RUN : ERROR;
        end
`endif
        default: ;
      endcase
    end

    case (r_state)
      LOAD, CHECK: ld_ready = 1'b1;
      RUN: begin
        cpu_reset_n = 1'b1;
        busy        = 1'b0;
      end
`ifdef IMEM_CHECKSUM_EN
      ERROR:   error = 1'b1;
`endif
      default: ;
    endcase
  end

  imem_array u_array (
    .clock   (clock),
    .reset   (reset),
    .i_we    (w_we),
    .i_waddr (r_idx),
    .i_wdata (ld_data),
    .i_raddr (addr),
    .o_rdata (data)
  );

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader. Builds with or without IMEM_CHECKSUM_EN.
module tb_imem_loader;
  import imem_loader_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] addr = 4'h0;
  logic [7:0] data;
  logic       load_req = 1'b0;
  logic       ld_valid = 1'b0;
  logic [7:0] ld_data = 8'h00;
  logic       ld_ready;
  logic       cpu_reset_n;
  logic       busy;
  logic       error;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [3:0] a;
    logic [7:0] d;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] model [16];

  imem_loader dut (
    .clock       (clock),
    .reset       (reset),
    .addr        (addr),
    .data        (data),
    .load_req    (load_req),
    .ld_valid    (ld_valid),
    .ld_data     (ld_data),
    .ld_ready    (ld_ready),
    .cpu_reset_n (cpu_reset_n),
    .busy        (busy),
    .error       (error)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_status(input string tag, input logic rdy, input logic crn,
                              input logic bsy, input logic err);
    check({tag, ".ld_ready"}, 8'(ld_ready), 8'(rdy));
    check({tag, ".cpu_reset_n"}, 8'(cpu_reset_n), 8'(crn));
    check({tag, ".busy"}, 8'(busy), 8'(bsy));
    check({tag, ".error"}, 8'(error), 8'(err));
  endtask

  // Queue the expected contents of every word, then read them all back.
  task automatic check_mem(input string tag);
    exp_t e;
    for (int i = 0; i < 16; i++) exp_q.push_back('{a: 4'(i), d: model[i]});
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      addr = e.a;
      #1;
      check($sformatf("%s.mem[%0d]", tag, e.a), data, e.d);
    end
  endtask

  task automatic send(input logic [7:0] b);
    ld_valid = 1'b1;
    ld_data  = b;
    tick();
    ld_valid = 1'b0;
  endtask

  task automatic pulse_load_req();
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) model[i] = 8'h00;

    // Reset state
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    check_status("reset", 1'b1, 1'b0, 1'b1, 1'b0);
    check_mem("reset");

    // Back-to-back load of 30..3F
    for (int i = 0; i < 16; i++) begin
      send(8'h30 + 8'(i));
      model[i] = 8'h30 + 8'(i);
      if (i == 14) check_status("load1.mid", 1'b1, 1'b0, 1'b1, 1'b0);
    end
`ifdef IMEM_CHECKSUM_EN
    check_status("load1.check", 1'b1, 1'b0, 1'b1, 1'b0);
    send(8'h88);
`endif
    check_status("load1.run", 1'b0, 1'b1, 1'b0, 1'b0);
    addr = 4'h5;
    #1;
    check("load1.addr5", data, 8'h35);
    check_mem("load1");

    // ld_valid in RUN is ignored
    addr = 4'h0;
    send(8'hFF);
    check("run_ignore.mem0", data, 8'h30);
    check_status("run_ignore", 1'b0, 1'b1, 1'b0, 1'b0);

    // load_req in RUN
    pulse_load_req();
    check_status("req_run", 1'b1, 1'b0, 1'b1, 1'b0);

    // 7 bytes, then load_req with a concurrent transfer that must be dropped
    for (int i = 0; i < 7; i++) begin
      send(8'hA0 + 8'(i));
      model[i] = 8'hA0 + 8'(i);
    end
    load_req = 1'b1;
    ld_valid = 1'b1;
    ld_data  = 8'hEE;
    tick();
    load_req = 1'b0;
    ld_valid = 1'b0;
    check_status("req_drop", 1'b1, 1'b0, 1'b1, 1'b0);
    check_mem("req_drop");

    // First byte after restart lands at word 0; read shows old then new
    addr     = 4'h0;
    ld_valid = 1'b1;
    ld_data  = 8'hB0;
    #1;
    check("wbr.old", data, 8'hA0);
    tick();
    check("wbr.new", data, 8'hB0);
    model[0] = 8'hB0;
    ld_valid = 1'b0;
    ld_data  = 8'h55;
    tick();

    // ld_valid toggling every other cycle with junk data on idle cycles
    for (int i = 1; i < 16; i++) begin
      send(8'hB0 + 8'(i));
      model[i] = 8'hB0 + 8'(i);
      ld_data = 8'h55;
      if (i < 15) tick();
    end
`ifdef IMEM_CHECKSUM_EN
    send(8'h88);
`endif
    check_status("toggle.run", 1'b0, 1'b1, 1'b0, 1'b0);
    addr = 4'hF;
    #1;
    check("toggle.mem15", data, 8'hBF);
    check_mem("toggle");

`ifdef IMEM_CHECKSUM_EN
    // Good checksum
    pulse_load_req();
    for (int i = 0; i < 16; i++) begin
      send(8'h01);
      model[i] = 8'h01;
    end
    send(8'hF0);
    check_status("csum_ok", 1'b0, 1'b1, 1'b0, 1'b0);

    // Bad checksum
    pulse_load_req();
    for (int i = 0; i < 16; i++) send(8'h01);
    send(8'hF1);
    check_status("csum_bad", 1'b0, 1'b0, 1'b1, 1'b1);
    check_mem("csum_bad");

    // load_req in ERROR
    pulse_load_req();
    check_status("req_err", 1'b1, 1'b0, 1'b1, 1'b0);
`else
    pulse_load_req();
`endif

    // Reset in the middle of a load
    for (int i = 0; i < 9; i++) send(8'hC0 + 8'(i));
    reset = 1'b0;
    tick();
    reset = 1'b1;
    for (int i = 0; i < 16; i++) model[i] = 8'h00;
    check_status("rst_mid", 1'b1, 1'b0, 1'b1, 1'b0);
    check_mem("rst_mid");
    send(8'hD0);
    model[0] = 8'hD0;
    check_mem("rst_idx");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time instruction memory for the 4-bit CPU: a 16×8 program store with combinational fetch, filled through a byte-wide valid/ready load port. It sits directly upstream of the CPU, driving its instruction `data` from the CPU's fetch address. It also owns the CPU's reset line, holding the core in reset until a complete program is loaded (and, optionally, checksum-verified).

## Interface
Parameters:
- `DEPTH`, 16, number of instruction words; fixed by the 4-bit address space.

Ports:
- `clock` input 1: system clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-low.
- `addr` input 4: CPU fetch address (`virt_addr.addr`).
- `data` output 8 (`data_t`): instruction at `addr`, `{opcode[7:4], imm[3:0]}`.
- `load_req` input 1: single-cycle pulse; starts or restarts a load.
- `ld_valid` input 1: load byte valid.
- `ld_data` input 8: load byte.
- `ld_ready` output 1: block accepts a byte this cycle.
- `cpu_reset_n` output 1: drives the CPU `reset`; 0 holds the CPU in reset.
- `busy` output 1: high whenever state ≠ RUN.
- `error` output 1: high in ERROR.

## Operation
- States: LOAD, CHECK (only with the macro), RUN, ERROR.
- Reset (`reset`=0):
  - state←LOAD, word index←0, sum←0, all 16 words←8'h00.
  - `cpu_reset_n`=0, `busy`=1, `error`=0, `ld_ready`=1.
- Transfer: `ld_valid`&&`ld_ready` at a rising edge.
- LOAD, on each transfer:
  - mem[idx]←`ld_data`, idx←idx+1, sum←(sum+`ld_data`) mod 256.
  - The transfer at idx=15 moves to CHECK (macro defined) or RUN (macro undefined). idx wraps to 0.
- CHECK, on a transfer:
  - If (sum+`ld_data`) mod 256 == 0, go to RUN; otherwise go to ERROR.
  - The checksum byte is not stored.
- RUN: `ld_ready`=0, `cpu_reset_n`=1, memory is read-only.
- ERROR: `ld_ready`=0, `cpu_reset_n`=0, `error`=1.
- `load_req`=1, in any state:
  - state←LOAD, idx←0, sum←0, `error`←0.
  - A transfer in the same cycle is dropped, not written.
  - Memory contents are retained until overwritten.
- `ld_valid` outside LOAD/CHECK: ignored.
- Fetch: `data`=mem[`addr`], combinational in every state.

## Timing
- All outputs except `data` are registered, decoded from the state register. They update on the same edge that changes state.
- Last-byte (or checksum-byte) edge: `cpu_reset_n` rises after it. The CPU's first active edge is the following one, fetching address 0.
- `load_req` edge: `cpu_reset_n` falls after it. The CPU's next edge is a reset edge.
- Write then read at the same address in the same cycle: `data` shows the old word and the new word one cycle later (write-before-read is not bypassed).
- Full load latency with back-to-back `ld_valid`: 16 cycles without the macro, 17 with it.
- Stalls: `ld_valid` gaps of any length are allowed; no timeout.
- Reset mid-load: the partial program is discarded, memory is zeroed and the block returns to LOAD at idx 0.

## Configuration
- `IMEM_CHECKSUM_EN` defined:
  - CHECK state exists; the 17th byte is a two's-complement checksum.
  - A mismatch leads to ERROR.
- Undefined:
  - No CHECK state; the sum register is removed.
  - `error` is tied to 0; ERROR is unreachable.
  - The transfer at idx=15 goes directly to RUN.

## Structure
- Shared package: `loader_state_t` enum (LOAD, CHECK, RUN, ERROR) and the `IMEM_DEPTH`=16 constant. `data_t` stays in the existing types header.
- Sub-module `imem_array`: 16×8 register file with synchronous write, asynchronous read and synchronous clear on reset. The FSM, index, checksum and handshake stay in `imem_loader`.

## Test plan
- Reset, then 16 back-to-back bytes 8'h30..8'h3F (macro off):
  - `ld_ready` drops and `cpu_reset_n`=1 after the 16th edge.
  - `addr`=4'h5 gives `data`=8'h35.
- Macro on: 16 bytes of 8'h01, then checksum 8'hF0:
  - RUN, `error`=0.
  - Repeat with checksum 8'hF1: ERROR, `error`=1, `cpu_reset_n`=0, `ld_ready`=0.
- `ld_valid` toggling every other cycle during load:
  - Exactly 16 writes, in order.
  - mem[15] holds the 16th accepted byte.
- `load_req` pulse with a concurrent transfer after 7 bytes:
  - The concurrent byte is not written; idx=0.
  - mem[7..15] keep their old values until reloaded.
- `load_req` in RUN: `cpu_reset_n`=0 and `busy`=1 the next cycle. `load_req` in ERROR: `error` clears and `ld_ready`=1.
- Reset asserted after 9 bytes: all words read 8'h00 and the block is in LOAD with idx 0.
